// File: rtl/mips32_pipe_core_if.sv
// Memory bus bundle for mips32_pipe_core: instruction fetch and data port.
// master = core side (drives addresses/store), slave = memory side.
interface mips32_pipe_core_if #(
  parameter int DATA_W  = 32,
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 10
);
  logic [IADDR_W-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    output dmem_rdata
  );
endinterface

// File: rtl/mips32_pipe_core.sv
// Five-stage in-order MIPS32-subset core (IF ID EX MEM WB), single clock.
// Ports: clk, rst (sync, high), bus (imem/dmem), halted, retire, dbg_raddr/dbg_rdata.
module mips32_pipe_core #(
  parameter int DATA_W   = 32,
  parameter int IADDR_W  = 10,
  parameter int DADDR_W  = 10,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mips32_pipe_core_if.master   bus,
  output logic                 halted,
  output logic                 retire,
  input  logic [4:0]           dbg_raddr,
  output logic [DATA_W-1:0]    dbg_rdata
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
  } alu_op_e;

  typedef struct packed {
    logic               v;
    logic [IADDR_W-1:0] pc;
    logic [31:0]        ir;
  } if_id_t;

  typedef struct packed {
    logic               v;
    logic [IADDR_W-1:0] pc;
    alu_op_e            op;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  imm;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         dst;
    logic               use_imm;
    logic               wen;
    logic               lw;
    logic               sw;
    logic               beqz;
    logic               bneqz;
    logic               hlt;
  } id_ex_t;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
    logic [4:0]        dst;
    logic              wen;
    logic              lw;
    logic              sw;
    logic              hlt;
  } ex_mem_t;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] res;
    logic [4:0]        dst;
    logic              wen;
    logic              hlt;
  } mem_wb_t;

  logic [IADDR_W-1:0] pc;
  if_id_t             ifid;
  id_ex_t             idex, id_nxt;
  ex_mem_t            exmem, ex_nxt;
  mem_wb_t            memwb, mem_nxt;
  logic               halted_q;
  logic [DATA_W-1:0]  rf [32];

  logic               wb_we;
  logic [DATA_W-1:0]  rd_a, rd_b;
  logic               uses_rs, uses_rt;
  logic               load_use, hlt_pend, br_taken;
  logic [IADDR_W-1:0] br_tgt;
  logic [DATA_W-1:0]  fa, fb, opb;

  assign wb_we = memwb.v & memwb.wen & (memwb.dst != 5'd0);

  // ID read port, write-first against the WB write
  always_comb begin
    rd_a = rf[ifid.ir[25:21]];
    rd_b = rf[ifid.ir[20:16]];
    if (wb_we && memwb.dst == ifid.ir[25:21]) rd_a = memwb.res;
    if (wb_we && memwb.dst == ifid.ir[20:16]) rd_b = memwb.res;
    if (ifid.ir[25:21] == 5'd0) rd_a = '0;
    if (ifid.ir[20:16] == 5'd0) rd_b = '0;
  end

  always_comb begin
    logic [5:0] opc;
    logic       rr, rm;
    opc        = ifid.ir[31:26];
    rr         = 1'b0;
    rm         = 1'b0;
    uses_rs    = 1'b1;
    uses_rt    = 1'b0;
    id_nxt     = '0;
    id_nxt.v   = ifid.v;
    id_nxt.pc  = ifid.pc;
    id_nxt.op  = ALU_ADD;
    id_nxt.a   = rd_a;
    id_nxt.b   = rd_b;
    id_nxt.imm = DATA_W'($signed(ifid.ir[15:0]));
    id_nxt.rs  = ifid.ir[25:21];
    id_nxt.rt  = ifid.ir[20:16];
    unique case (1'b1)
      (opc == OP_ADD):   begin id_nxt.op = ALU_ADD; rr = 1'b1; end
      (opc == OP_SUB):   begin id_nxt.op = ALU_SUB; rr = 1'b1; end
      (opc == OP_AND):   begin id_nxt.op = ALU_AND; rr = 1'b1; end
      (opc == OP_OR):    begin id_nxt.op = ALU_OR;  rr = 1'b1; end
      (opc == OP_SLT):   begin id_nxt.op = ALU_SLT; rr = 1'b1; end
      (opc == OP_MUL):   begin id_nxt.op = ALU_MUL; rr = 1'b1; end
      (opc == OP_ADDI):  begin id_nxt.op = ALU_ADD; rm = 1'b1; end
      (opc == OP_SUBI):  begin id_nxt.op = ALU_SUB; rm = 1'b1; end
      (opc == OP_SLTI):  begin id_nxt.op = ALU_SLT; rm = 1'b1; end
      (opc == OP_LW):    begin id_nxt.lw = 1'b1;    rm = 1'b1; end
      (opc == OP_SW): begin
        id_nxt.sw      = 1'b1;
        id_nxt.use_imm = 1'b1;
        uses_rt        = 1'b1;
      end
      (opc == OP_BEQZ):  id_nxt.beqz  = 1'b1;
      (opc == OP_BNEQZ): id_nxt.bneqz = 1'b1;
      default: begin
        id_nxt.hlt = 1'b1;
        uses_rs    = 1'b0;
      end
    endcase
    if (rr) begin
      id_nxt.wen = 1'b1;
      id_nxt.dst = ifid.ir[15:11];
      uses_rt    = 1'b1;
    end
    if (rm) begin
      id_nxt.wen     = 1'b1;
      id_nxt.dst     = ifid.ir[20:16];
      id_nxt.use_imm = 1'b1;
    end
  end

  assign load_use = idex.v & idex.lw & (idex.dst != 5'd0) & ifid.v &
                    ((uses_rs & (id_nxt.rs == idex.dst)) |
                     (uses_rt & (id_nxt.rt == idex.dst)));

  assign hlt_pend = (ifid.v & id_nxt.hlt) | (idex.v & idex.hlt) |
                    (exmem.v & exmem.hlt) | (memwb.v & memwb.hlt);

  // EX: forwarding (EX/MEM first, loads only from MEM/WB), ALU, branch
  always_comb begin
    logic fwd_ok_em, fwd_ok_mw;
    fwd_ok_em = exmem.v & exmem.wen & ~exmem.lw & (exmem.dst != 5'd0);
    fwd_ok_mw = wb_we;
    fa = idex.a;
    fb = idex.b;
    if (fwd_ok_em && exmem.dst == idex.rs)      fa = exmem.alu;
    else if (fwd_ok_mw && memwb.dst == idex.rs) fa = memwb.res;
    if (fwd_ok_em && exmem.dst == idex.rt)      fb = exmem.alu;
    else if (fwd_ok_mw && memwb.dst == idex.rt) fb = memwb.res;
    opb = idex.use_imm ? idex.imm : fb;

    ex_nxt     = '0;
    ex_nxt.v   = idex.v;
    ex_nxt.sd  = fb;
    ex_nxt.dst = idex.dst;
    ex_nxt.wen = idex.wen;
    ex_nxt.lw  = idex.lw;
    ex_nxt.sw  = idex.sw;
    ex_nxt.hlt = idex.hlt;
    unique case (idex.op)
      ALU_SUB: ex_nxt.alu = fa - opb;
      ALU_AND: ex_nxt.alu = fa & opb;
      ALU_OR:  ex_nxt.alu = fa | opb;
      ALU_SLT: ex_nxt.alu = DATA_W'(fa < opb);
      ALU_MUL: ex_nxt.alu = fa * opb;
      default: ex_nxt.alu = fa + opb;
    endcase

    br_taken = idex.v & ((idex.beqz  & (fa == '0)) |
                         (idex.bneqz & (fa != '0)));
    br_tgt   = idex.pc + IADDR_W'(1) + idex.imm[IADDR_W-1:0];
  end

  always_comb begin
    mem_nxt     = '0;
    mem_nxt.v   = exmem.v;
    mem_nxt.res = exmem.lw ? bus.dmem_rdata : exmem.alu;
    mem_nxt.dst = exmem.dst;
    mem_nxt.wen = exmem.wen;
    mem_nxt.hlt = exmem.hlt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= IADDR_W'(RESET_PC);
      ifid     <= '0;
      idex     <= '0;
      exmem    <= '0;
      memwb    <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halted_q) begin
      if (memwb.v && memwb.hlt) halted_q <= 1'b1;
      if (wb_we) rf[memwb.dst] <= memwb.res;

      if (br_taken) begin
        pc   <= br_tgt;
        ifid <= '0;
        idex <= '0;
      end else if (load_use) begin
        idex <= '0;
      end else begin
        if (!hlt_pend) pc <= pc + IADDR_W'(1);
        ifid.v  <= ~hlt_pend;
        ifid.pc <= pc;
        ifid.ir <= bus.imem_rdata;
        idex    <= id_nxt;
      end

      exmem <= ex_nxt;
      memwb <= mem_nxt;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = exmem.alu[DADDR_W-1:0];
  assign bus.dmem_wdata = exmem.sd;
  assign bus.dmem_we    = exmem.v & exmem.sw & ~halted_q;

  assign halted    = halted_q | (memwb.v & memwb.hlt);
  assign retire    = memwb.v & ~halted_q;
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf[dbg_raddr];

endmodule

// File: tb/tb_mips32_pipe_core.sv
// Scoreboarded bench for mips32_pipe_core: directed programs, retire-cycle
// queue checked by a monitor, final state read through the debug port.
module tb_mips32_pipe_core;

  localparam int DW = 32;
  localparam int IW = 10;
  localparam int AW = 10;

  localparam logic [5:0] ADD = 6'b000000, SUBO = 6'b000001, MUL = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] BEQZ = 6'b001110, BNEQZ = 6'b001101, HLT = 6'b111111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          halted, retire;
  logic [4:0]    dbg_raddr = '0;
  logic [DW-1:0] dbg_rdata;

  logic [31:0] imem [1024];
  logic [DW-1:0] dmem [1024];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int q[$];
  bit mon_en = 1'b0;
  bit seen_halt = 1'b0;
  int halt_cyc = -1;

  mips32_pipe_core_if #(.DATA_W(DW), .IADDR_W(IW), .DADDR_W(AW)) bus ();

  mips32_pipe_core #(
    .DATA_W(DW), .IADDR_W(IW), .DADDR_W(AW), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .halted(halted),
    .retire(retire),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];

  always @(posedge clk) begin
    if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    cyc <= rst ? 0 : cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every retire pulse must match the next expected cycle
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (retire) begin
        if (q.size() == 0) begin
          chk("retire_extra", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          chk("retire_cyc", 32'(cyc), 32'(q.pop_front()));
        end
      end
      if (halted && !seen_halt) begin
        seen_halt = 1'b1;
        halt_cyc  = cyc;
      end
    end
  end

  function automatic logic [31:0] r_op(input logic [5:0] op, input int rd,
                                       input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rt,
                                       input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clr_imem();
    for (int i = 0; i < 1024; i++) imem[i] = {HLT, 26'd0};
  endtask

  task automatic load_loop();
    clr_imem();
    imem[0] = i_op(ADDI, 1, 0, 3);
    imem[1] = i_op(ADDI, 2, 2, 5);
    imem[2] = i_op(SUBI, 1, 1, 1);
    imem[3] = i_op(BNEQZ, 0, 1, -3);
    imem[4] = {HLT, 26'd0};
  endtask

  task automatic push_loop();
    int e[11] = '{4, 5, 6, 7, 10, 11, 12, 15, 16, 17, 18};
    foreach (e[i]) q.push_back(e[i]);
  endtask

  task automatic launch();
    rst       = 1'b1;
    mon_en    = 1'b0;
    seen_halt = 1'b0;
    halt_cyc  = -1;
    q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic go(input bit en);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = en;
  endtask

  task automatic wait_halt(input int budget, input int exp_hc);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    repeat (4) @(negedge clk);
    chk("retire_left", 32'(q.size()), 32'd0);
    chk("halt_cyc", 32'(halt_cyc), 32'(exp_hc));
  endtask

  task automatic rchk(input string name, input int idx,
                      input logic [31:0] exp);
    dbg_raddr = 5'(idx);
    #1;
    chk(name, dbg_rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = '0;

    // forwarding
    clr_imem();
    imem[0] = i_op(ADDI, 1, 0, 10);
    imem[1] = i_op(ADDI, 2, 0, 20);
    imem[2] = r_op(ADD, 3, 1, 2);
    launch();
    #1;
    chk("rst_pc", 32'(bus.imem_addr), 32'd0);
    chk("rst_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rchk("rst_r1", 1, 32'd0);
    q = '{4, 5, 6, 7};
    go(1'b1);
    wait_halt(200, 7);
    rchk("fwd_r3", 3, 32'd30);
    rchk("fwd_r1", 1, 32'd10);

    // load-use
    clr_imem();
    imem[0] = i_op(ADDI, 1, 0, 7);
    imem[1] = i_op(SW, 1, 0, 5);
    imem[2] = i_op(LW, 4, 0, 5);
    imem[3] = r_op(ADD, 5, 4, 4);
    launch();
    q = '{4, 5, 6, 8, 9};
    go(1'b1);
    wait_halt(200, 9);
    chk("lu_mem5", dmem[5], 32'd7);
    rchk("lu_r4", 4, 32'd7);
    rchk("lu_r5", 5, 32'd14);

    // taken branch flushes two shadow instructions
    clr_imem();
    imem[0] = i_op(ADDI, 1, 0, 0);
    imem[1] = i_op(BEQZ, 0, 1, 2);
    imem[2] = i_op(ADDI, 6, 0, 99);
    imem[3] = i_op(ADDI, 6, 0, 98);
    imem[4] = i_op(ADDI, 7, 0, 1);
    launch();
    q = '{4, 5, 8, 9};
    go(1'b1);
    wait_halt(200, 9);
    rchk("br_r6", 6, 32'd0);
    rchk("br_r7", 7, 32'd1);

    // loop with BNEQZ
    load_loop();
    launch();
    push_loop();
    go(1'b1);
    wait_halt(300, 18);
    rchk("loop_r1", 1, 32'd0);
    rchk("loop_r2", 2, 32'd15);

    // corner ops and unknown opcode
    clr_imem();
    imem[0] = i_op(ADDI, 0, 0, 5);
    imem[1] = i_op(ADDI, 1, 0, 16384);
    imem[2] = r_op(MUL, 2, 1, 1);
    imem[3] = i_op(ADDI, 3, 0, 8);
    imem[4] = r_op(MUL, 2, 2, 3);
    imem[5] = i_op(ADDI, 4, 0, 4);
    imem[6] = r_op(MUL, 5, 2, 4);
    imem[7] = i_op(SLTI, 6, 0, -1);
    imem[8] = {6'b111000, 26'd0};
    imem[9] = i_op(ADDI, 7, 0, 1);
    launch();
    q = '{4, 5, 6, 7, 8, 9, 10, 11, 12};
    go(1'b1);
    wait_halt(200, 12);
    rchk("cor_r0", 0, 32'd0);
    rchk("cor_r2", 2, 32'h8000_0000);
    rchk("cor_r5", 5, 32'd0);
    rchk("cor_r6", 6, 32'd1);
    rchk("cor_r7", 7, 32'd0);

    // reset in the middle of the loop
    load_loop();
    launch();
    go(1'b0);
    begin
      int n = 0;
      while (cyc != 8 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reach", 32'(cyc), 32'd8);
    end
    rchk("mid_r2_pre", 2, 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_pc", 32'(bus.imem_addr), 32'd0);
    chk("mid_we", 32'(bus.dmem_we), 32'd0);
    chk("mid_retire", 32'(retire), 32'd0);
    rchk("mid_r1", 1, 32'd0);
    rchk("mid_r2", 2, 32'd0);
    rst       = 1'b0;
    seen_halt = 1'b0;
    halt_cyc  = -1;
    q.delete();
    push_loop();
    mon_en = 1'b1;
    wait_halt(300, 18);
    rchk("rerun_r1", 1, 32'd0);
    rchk("rerun_r2", 2, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
